// File: rtl/jtframe_joy_pkg.sv
// rtl/jtframe_joy_pkg.sv - shared constants and slot-to-button map for the joystick shifter
// Contents:
//   JOY_W          button vector width per player
//   FRAME_LEN_DEF  default number of serial slots per scan frame
//   FIRST_SLOT     first slot that carries button data (earlier slots are discarded)
//   joy_map()      slot number -> {used, player 2 select, button bit index}
package jtframe_joy_pkg;

    localparam int JOY_W         = 12;
    localparam int FRAME_LEN_DEF = 26;
    localparam int FIRST_SLOT    = 2;

    // Button bit order for the eight main slots of each player, nibble i = slot FIRST_SLOT+i
    localparam logic [31:0] MAIN_ORDER  = {4'd3, 4'd2, 4'd1, 4'd0, 4'd4, 4'd5, 4'd6, 4'd8};
    // Bit order for the four extra buttons, nibble i = i-th extra slot
    localparam logic [15:0] EXTRA_ORDER = {4'd7, 4'd9, 4'd11, 4'd10};

    typedef struct packed {
        logic       used;
        logic       p2;
        logic [3:0] idx;
    } joy_map_t;

    function automatic joy_map_t joy_map(input int slot);
        joy_map_t m;
        m = '0;
        if (slot < FIRST_SLOT) begin
            m.used = 1'b0;
        end else if (slot < FIRST_SLOT + 8) begin
            m.used = 1'b1;
            m.p2   = 1'b0;
            m.idx  = MAIN_ORDER[4*(slot - FIRST_SLOT) +: 4];
        end else if (slot < FIRST_SLOT + 16) begin
            m.used = 1'b1;
            m.p2   = 1'b1;
            m.idx  = MAIN_ORDER[4*(slot - FIRST_SLOT - 8) +: 4];
        end else if (slot < FIRST_SLOT + 20) begin
            // extra buttons arrive for player 2 first
            m.used = 1'b1;
            m.p2   = 1'b1;
            m.idx  = EXTRA_ORDER[4*(slot - FIRST_SLOT - 16) +: 4];
        end else if (slot < FIRST_SLOT + 24) begin
            m.used = 1'b1;
            m.p2   = 1'b0;
            m.idx  = EXTRA_ORDER[4*(slot - FIRST_SLOT - 20) +: 4];
        end
        return m;
    endfunction

endpackage

// File: rtl/jtframe_joy_shift_if.sv
// rtl/jtframe_joy_shift_if.sv - joystick shift-register link and decoded button outputs
// Signals:
//   joy_clk    shift clock to the external shift register
//   joy_load   parallel-load strobe, active low
//   joy_data   serial button data, active low
//   joy1/joy2  published player buttons, active high
//   joy_valid  one-cycle pulse when joy1/joy2 are republished
// Modports: master = scanner (jtframe_joy_shift), slave = pad side / consumer.
interface jtframe_joy_shift_if import jtframe_joy_pkg::*; ();

    logic             joy_clk;
    logic             joy_load;
    logic             joy_data;
    logic [JOY_W-1:0] joy1;
    logic [JOY_W-1:0] joy2;
    logic             joy_valid;

    modport master (
        output joy_clk, joy_load, joy1, joy2, joy_valid,
        input  joy_data
    );

    modport slave (
        input  joy_clk, joy_load, joy1, joy2, joy_valid,
        output joy_data
    );

endinterface

// File: rtl/jtframe_joy_debounce.sv
// rtl/jtframe_joy_debounce.sv - two-frame agreement filter for published button bits
// Built only when JTFRAME_JOY_DEBOUNCE_EN is defined.
// Ports:
//   clk_sys, rst  system clock, asynchronous active-high reset
//   publish       end-of-frame strobe; captures cur as the previous frame
//   cur           freshly scanned frame
//   held          currently published outputs
//   next          value to publish: cur where it matches last frame, held elsewhere
`ifdef JTFRAME_JOY_DEBOUNCE_EN
module jtframe_joy_debounce #(
    parameter int W = 24
) (
    input  logic         clk_sys,
    input  logic         rst,
    input  logic         publish,
    input  logic [W-1:0] cur,
    input  logic [W-1:0] held,
    output logic [W-1:0] next
);

    logic [W-1:0] prev;
    logic [W-1:0] stable;

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            prev <= '0;
        end else if (publish) begin
            prev <= cur;
        end
    end

    assign stable = ~(cur ^ prev);
    assign next   = (stable & cur) | (~stable & held);

endmodule
`endif

// File: rtl/jtframe_joy_shift.sv
// rtl/jtframe_joy_shift.sv - serial joystick scanner for two 12-button pads
// Ports:
//   clk_sys   system clock, all logic on its rising edge
//   rst       asynchronous active-high reset
//   joy       jtframe_joy_shift_if.master: joy_clk/joy_load/joy_data link, joy1/joy2/joy_valid
// Parameters: DIV_W (joy_clk period is 2^DIV_W cycles), FRAME_LEN (slots per frame).
// Option: JTFRAME_JOY_DEBOUNCE_EN publishes a bit only once two frames agree.
module jtframe_joy_shift
    import jtframe_joy_pkg::*;
#(
    parameter int DIV_W     = 8,
    parameter int FRAME_LEN = FRAME_LEN_DEF
) (
    input  logic                clk_sys,
    input  logic                rst,
    jtframe_joy_shift_if.master joy
);

    localparam int               SLOT_W    = $clog2(FRAME_LEN);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME_LEN - 1);
    // One cycle before the divider MSB rises, so slot updates land on the joy_clk rising edge
    localparam logic [DIV_W-1:0]  TICK_AT   = {1'b0, {(DIV_W-1){1'b1}}};

    logic [DIV_W-1:0]  div;
    logic [SLOT_W-1:0] slot;
    logic              tick;
    logic              publish;

    logic [JOY_W-1:0]  sh1, sh2;
    logic [JOY_W-1:0]  sh1_nx, sh2_nx;
    logic [JOY_W-1:0]  pub1, pub2;
    logic [JOY_W-1:0]  joy1_q, joy2_q;
    logic              joy_load_q;
    logic              joy_valid_q;
    joy_map_t          m;

    assign tick    = (div == TICK_AT);
    assign publish = tick && (slot == LAST_SLOT);

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            div  <= '0;
            slot <= '0;
        end else begin
            div <= div + DIV_W'(1);
            if (tick) begin
                slot <= (slot == LAST_SLOT) ? '0 : slot + SLOT_W'(1);
            end
        end
    end

    // Sample for the current slot merged into the shadow copy; also feeds the
    // publish path so the last slot of the frame is included in the same edge.
    always_comb begin
        sh1_nx = sh1;
        sh2_nx = sh2;
        m      = joy_map(int'(slot));
        if (tick && m.used) begin
            if (m.p2) begin
                sh2_nx[m.idx] = ~joy.joy_data;
            end else begin
                sh1_nx[m.idx] = ~joy.joy_data;
            end
        end
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            sh1 <= '0;
            sh2 <= '0;
        end else begin
            sh1 <= sh1_nx;
            sh2 <= sh2_nx;
        end
    end

`ifdef JTFRAME_JOY_DEBOUNCE_EN
    jtframe_joy_debounce #(
        .W (2*JOY_W)
    ) u_debounce (
        .clk_sys (clk_sys),
        .rst     (rst),
        .publish (publish),
        .cur     ({sh2_nx, sh1_nx}),
        .held    ({joy2_q, joy1_q}),
        .next    ({pub2, pub1})
    );
`else
    assign pub1 = sh1_nx;
    assign pub2 = sh2_nx;
`endif

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            joy1_q      <= '0;
            joy2_q      <= '0;
            joy_valid_q <= 1'b0;
            joy_load_q  <= 1'b1;
        end else begin
            joy_valid_q <= publish;
            joy_load_q  <= (slot != '0);
            if (publish) begin
                joy1_q <= pub1;
                joy2_q <= pub2;
            end
        end
    end

    assign joy.joy_clk   = div[DIV_W-1];
    assign joy.joy_load  = joy_load_q;
    assign joy.joy1      = joy1_q;
    assign joy.joy2      = joy2_q;
    assign joy.joy_valid = joy_valid_q;

endmodule

// File: tb/tb_jtframe_joy_shift.sv
// tb/tb_jtframe_joy_shift.sv - directed table-driven bench for jtframe_joy_shift (DIV_W=4)
module tb_jtframe_joy_shift;

    localparam int NV    = 8;
    localparam int FLEN  = 26;
    localparam int FCYC  = 416;
    localparam int FIRST = 408;

    typedef struct {
        logic [25:0] pressed;
        logic [11:0] e1;
        logic [11:0] e2;
    } vec_t;

    logic clk_sys = 1'b0;
    logic rst     = 1'b1;

    jtframe_joy_shift_if joy_if ();

    jtframe_joy_shift #(
        .DIV_W     (4),
        .FRAME_LEN (FLEN)
    ) dut (
        .clk_sys (clk_sys),
        .rst     (rst),
        .joy     (joy_if)
    );

    always #5 clk_sys = ~clk_sys;

    vec_t vecs [NV];
    int   applied     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   base        = 0;

    int   load_err  = 0;
    int   clk_err   = 0;
    int   bad_valid = 0;
    int   win_low   = 0;
    int   win_clkhi = 0;
    logic win_en    = 1'b0;

    int          drv_t, drv_f;
    logic [25:0] drv_pm;

    function automatic int ticks_of(input int c);
        return (c >= 8) ? (c - 8) / 16 + 1 : 0;
    endfunction

    always @(posedge clk_sys or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Serial pad model: slot s of frame f presents ~vecs[f+base].pressed[s]
    always @(negedge clk_sys) begin
        drv_t  = ticks_of(cyc);
        drv_f  = drv_t / FLEN + base;
        drv_pm = (drv_f < NV) ? vecs[drv_f].pressed : '1;
        joy_if.joy_data = ~drv_pm[drv_t % FLEN];
    end

    always @(negedge clk_sys) begin
        if (!rst && cyc >= 1) begin
            if (joy_if.joy_load !== ((ticks_of(cyc - 1) % FLEN) != 0)) load_err++;
            if (joy_if.joy_clk  !== ((cyc % 16) >= 8))                 clk_err++;
            if (joy_if.joy_valid && !(cyc >= FIRST && (cyc - FIRST) % FCYC == 0)) bad_valid++;
            if (win_en && cyc >= 9 && cyc < 9 + 7*FCYC) begin
                if (!joy_if.joy_load) win_low++;
                if (joy_if.joy_clk)   win_clkhi++;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_pub(output int pc);
        pc = -1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk_sys);
            if (joy_if.joy_valid === 1'b1) begin
                pc = cyc;
                break;
            end
        end
    endtask

    int pc;

    initial begin
        vecs[0] = '{26'h0000000, 12'h000, 12'h000};
        vecs[1] = '{26'h0100004, 12'h100, 12'h200};
        vecs[2] = '{26'h0000040, 12'h001, 12'h000};
        vecs[3] = '{26'h3FFFFFF, 12'hFFF, 12'hFFF};
        vecs[4] = '{26'h003FC00, 12'h000, 12'h17F};
        vecs[5] = '{26'h3C00000, 12'hE80, 12'h000};
        vecs[6] = '{26'h0000003, 12'h000, 12'h000};
        vecs[7] = '{26'h2040200, 12'h088, 12'h400};
        joy_if.joy_data = 1'b1;

        repeat (3) @(negedge clk_sys);
        check("rst_joy1",  32'(joy_if.joy1), 32'h0);
        check("rst_joy2",  32'(joy_if.joy2), 32'h0);
        check("rst_load",  32'(joy_if.joy_load), 32'h1);
        check("rst_clk",   32'(joy_if.joy_clk), 32'h0);
        check("rst_valid", 32'(joy_if.joy_valid), 32'h0);

        #1 rst = 1'b0;
        win_en = 1'b1;

        for (int k = 0; k < NV; k++) begin
            wait_pub(pc);
            check($sformatf("v%0d_pub_cycle", k), 32'(pc), 32'(FIRST + FCYC*k));
            check($sformatf("v%0d_joy1", k), 32'(joy_if.joy1), 32'(vecs[k].e1));
            check($sformatf("v%0d_joy2", k), 32'(joy_if.joy2), 32'(vecs[k].e2));
            @(negedge clk_sys);
            check($sformatf("v%0d_valid_width", k), 32'(joy_if.joy_valid), 32'h0);
            repeat (200) @(negedge clk_sys);
            check($sformatf("v%0d_joy1_hold", k), 32'(joy_if.joy1), 32'(vecs[k].e1));
            check($sformatf("v%0d_joy2_hold", k), 32'(joy_if.joy2), 32'(vecs[k].e2));
        end
        win_en = 1'b0;

        // Abort the all-pressed frame in slot 12; restart with vecs[1] as frame 0
        for (int i = 0; i < 1000 && (ticks_of(cyc) % FLEN) != 12; i++) @(negedge clk_sys);
        check("abort_slot", 32'(ticks_of(cyc) % FLEN), 32'd12);
        #1 rst = 1'b1;
        base = 1;
        @(negedge clk_sys);
        check("abort_joy1",  32'(joy_if.joy1), 32'h0);
        check("abort_joy2",  32'(joy_if.joy2), 32'h0);
        check("abort_valid", 32'(joy_if.joy_valid), 32'h0);
        check("abort_load",  32'(joy_if.joy_load), 32'h1);
        repeat (2) @(negedge clk_sys);
        #1 rst = 1'b0;
        @(negedge clk_sys);
        check("load_low_after_rst", 32'(joy_if.joy_load), 32'h0);
        check("joy1_after_rst", 32'(joy_if.joy1), 32'h0);
        wait_pub(pc);
        check("restart_pub_cycle", 32'(pc), 32'(FIRST));
        check("restart_joy1", 32'(joy_if.joy1), 32'h100);
        check("restart_joy2", 32'(joy_if.joy2), 32'h200);

        check("load_vs_slot_errors", 32'(load_err), 32'h0);
        check("clk_shape_errors",    32'(clk_err), 32'h0);
        check("stray_valid_pulses",  32'(bad_valid), 32'h0);
        check("load_low_7_frames",   32'(win_low), 32'd112);
        check("clk_high_7_frames",   32'(win_clkhi), 32'd1456);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
